// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and feeds IF/ID.
// Redirects squash wrong-path data. A stall that arrives with an ack parks the word in a one-entry buffer.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_FETCH | request outstanding at PC; deliver on ack
// ST_DROP  | redirected while waiting; keep old request up and discard its data
// ST_HOLD  | fetched word buffered behind a stall; no request issued
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   input  logic        jump_i,
   input  logic [31:0] jump_addr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] pc4addr_o,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic        flush_o
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_DROP  = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc4_q, buf_pc4_d;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign redirect = jump_i | branch_i;
   assign target   = jump_i ? jump_addr_i : branch_addr_i;
   assign pc_plus4 = pc_q + 32'd4;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         drop_addr_q <= RESET_PC;
         buf_instr_q <= 32'h0;
         buf_pc4_q   <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
         buf_instr_q <= buf_instr_d;
         buf_pc4_q   <= buf_pc4_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      drop_addr_d   = drop_addr_q;
      buf_instr_d   = buf_instr_q;
      buf_pc4_d     = buf_pc4_q;
      imem_req_o    = 1'b0;
      imem_addr_o   = pc_q;
      instr_valid_o = 1'b0;
      instr_o       = 32'h0;
      pc4addr_o     = 32'h0;
      flush_o       = redirect & ~rst_i;

      case (state_q)
         ST_FETCH: begin
            imem_req_o  = 1'b1;
            imem_addr_o = pc_q;
            instr_o     = imem_data_i;
            pc4addr_o   = pc_plus4;
            if (redirect) begin
               pc_d = target;
               if (!imem_ack_i) begin
                  // the old request must stay on the bus until it is acked
                  drop_addr_d = pc_q;
                  state_d     = ST_DROP;
               end
            end else if (imem_ack_i) begin
               pc_d = pc_plus4;
               if (stall_i) begin
                  buf_instr_d = imem_data_i;
                  buf_pc4_d   = pc_plus4;
                  state_d     = ST_HOLD;
               end else begin
                  instr_valid_o = 1'b1;
               end
            end
         end
         ST_DROP: begin
            imem_req_o  = 1'b1;
            imem_addr_o = drop_addr_q;
            if (redirect) pc_d = target;
            if (imem_ack_i) state_d = ST_FETCH;
         end
         ST_HOLD: begin
            instr_o   = buf_instr_q;
            pc4addr_o = buf_pc4_q;
            if (redirect) begin
               pc_d    = target;
               state_d = ST_FETCH;
            end else if (!stall_i) begin
               instr_valid_o = 1'b1;
               state_d       = ST_FETCH;
            end
         end
         default: state_d = ST_FETCH;
      endcase

      if (rst_i) begin
         imem_req_o    = 1'b0;
         imem_addr_o   = RESET_PC;
         instr_valid_o = 1'b0;
         instr_o       = 32'h0;
         pc4addr_o     = 32'h0;
      end
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. It owns the PC, drives a variable-latency instruction-memory request/acknowledge interface, and produces the {PC+4, instruction} pair plus write and flush strobes for the IF/ID pipeline register directly downstream.
- It accepts stall from hazard detection and branch/jump redirects from ID.
- It guarantees that no wrong-path or stale instruction ever reaches IF/ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- stall_i  in  1  hazard stall: hold PC, do not write IF/ID
- branch_i  in  1  taken branch resolved in ID
- branch_addr_i  in  32  branch target
- jump_i  in  1  jump resolved in ID
- jump_addr_i  in  32  jump target
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address (= PC)
- imem_ack_i  in  1  memory returns data this cycle
- imem_data_i  in  32  instruction word, valid when imem_ack_i=1
- pc4addr_o  out  32  PC+4 of delivered instruction, to IF/ID
- instr_o  out  32  delivered instruction, to IF/ID
- instr_valid_o  out  1  IF/ID write enable
- flush_o  out  1  IF/ID flush

Behaviour:
- Reset (rst_i=1 at edge):
  - PC<=RESET_PC, state<=FETCH, buffer cleared.
  - While rst_i=1: imem_req_o=0, instr_valid_o=0, flush_o=0, instr_o=0, pc4addr_o=0, imem_addr_o=RESET_PC.
  - Reset mid-request abandons the request; an ack arriving during reset is ignored.
- States:
  - FETCH: imem_req_o=1, addr=PC.
  - DROP: imem_req_o=1, addr=old PC; returned data is discarded.
  - HOLD: imem_req_o=0; instruction is buffered.
- Request rule: imem_req_o and imem_addr_o stay stable from assertion until the ack cycle inclusive. An ack in the same cycle as the request (zero-wait) is legal.
- redirect = jump_i | branch_i. Target is jump_addr_i if jump_i, else branch_addr_i; jump wins if both are asserted.
- flush_o = redirect & ~rst_i, combinational, same cycle as the redirect.
- Priority: reset > redirect > stall > normal.
- FETCH, ack=1, no redirect, stall=0:
  - instr_valid_o=1 combinationally that cycle.
  - instr_o=imem_data_i, pc4addr_o=PC+4.
  - PC<=PC+4; stay in FETCH. Sustained throughput is 1 instr/cycle with a zero-wait memory.
- FETCH, ack=1, stall=1, no redirect:
  - instr_valid_o=0.
  - Capture {PC+4, data} into the buffer; PC<=PC+4; go to HOLD.
- HOLD:
  - instr_o/pc4addr_o come from the buffer; instr_valid_o=~stall_i.
  - When stall_i=0: go to FETCH.
  - No new request is issued while in HOLD.
- FETCH, ack=0, no redirect: remain in FETCH with the same address; stall_i has no effect.
- Redirect in FETCH with ack=1 (same cycle):
  - Data discarded, instr_valid_o=0.
  - PC<=target; stay in FETCH.
- Redirect in FETCH with ack=0:
  - PC<=target; go to DROP. The old address stays on imem_addr_o via a separate held-address register.
- Redirect in HOLD: buffer discarded, PC<=target, go to FETCH.
- DROP:
  - instr_valid_o=0 always.
  - On ack, go to FETCH; the target request starts the next cycle.
  - A further redirect in DROP only updates PC.
- Redirect overrides stall_i in every state.
- Arithmetic: PC+4 is a 32-bit add that wraps modulo 2^32 (32'hFFFF_FFFC+4=0). Targets are used as given; no alignment check.

Test Plan:
- Zero-wait memory (ack=1 whenever req), RESET_PC=0x0, 4 cycles after reset -> addr 0x0,0x4,0x8,0xC; instr_valid_o=1 each cycle; pc4addr_o=0x4,0x8,0xC,0x10.
- Memory acks 2 cycles after req -> req/addr=0x0 held stable 3 cycles; instr_valid_o pulses once with pc4addr_o=0x4; next addr=0x4.
- stall_i=1 during the ack of 0x8 (data 0xDEADBEEF) and held 3 cycles -> instr_valid_o=0, req=0 for 3 cycles; on release, instr_valid_o=1 with instr_o=0xDEADBEEF, pc4addr_o=0xC; next req addr=0xC.
- branch_i=1, branch_addr_i=0x100 while the 0x10 fetch is waiting -> flush_o=1 that cycle; addr stays 0x10 until ack; that data is not delivered; next req addr=0x100, delivered pc4addr_o=0x104.
- jump_i=1 (0x200) and branch_i=1 (0x300) together with stall_i=1 -> flush_o=1; next fetch addr=0x200.
- rst_i=1 mid-wait, then ack arrives during reset -> no instr_valid_o; after release req addr=RESET_PC. PC at 0xFFFF_FFFC delivers pc4addr_o=0x0.
